// File: rtl/cal_req_scheduler_if.sv
// Bus bundle between the requester ports / ALU and the request scheduler.
// master = scheduler side, slave = requesters + ALU side.
interface cal_req_scheduler_if #(
    parameter int NPORTS = 4,
    parameter int DW     = 32
);
    logic [NPORTS-1:0][3:0]    req_cmd_in;
    logic [NPORTS-1:0][1:0]    req_tag_in;
    logic [NPORTS-1:0][DW-1:0] req_data_in;
    logic [NPORTS-1:0][1:0]    out_resp;
    logic [NPORTS-1:0][1:0]    out_tag;
    logic [NPORTS-1:0][DW-1:0] out_data;
    logic                      alu_valid;
    logic [3:0]                alu_cmd;
    logic [DW-1:0]             alu_op1;
    logic [DW-1:0]             alu_op2;
    logic [1:0]                alu_port;
    logic [1:0]                alu_tag;
    logic                      alu_ready;
    logic                      res_valid;
    logic [1:0]                res_port;
    logic [1:0]                res_tag;
    logic [DW-1:0]             res_data;
    logic [1:0]                res_resp;

    modport master (
        input  req_cmd_in, req_tag_in, req_data_in,
        input  alu_ready, res_valid, res_port, res_tag, res_data, res_resp,
        output out_resp, out_tag, out_data,
        output alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag
    );

    modport slave (
        output req_cmd_in, req_tag_in, req_data_in,
        output alu_ready, res_valid, res_port, res_tag, res_data, res_resp,
        input  out_resp, out_tag, out_data,
        input  alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag
    );
endinterface

// File: rtl/cal_req_scheduler.sv
// Four-port calculator front end: per-port two-cycle command capture into a FIFO,
// round-robin issue to one shared ALU, and per-port result/reject return.
module cal_req_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd_i,
    input  logic [1:0]    tag_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    input  logic          res_hit_i,
    input  logic [1:0]    res_resp_i,
    input  logic [1:0]    res_tag_i,
    input  logic [DW-1:0] res_data_i,
    output logic          empty_o,
    output logic [3:0]    head_cmd_o,
    output logic [1:0]    head_tag_o,
    output logic [DW-1:0] head_op1_o,
    output logic [DW-1:0] head_op2_o,
    output logic [1:0]    resp_o,
    output logic [1:0]    tag_o,
    output logic [DW-1:0] data_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {ST_IDLE, ST_OP2} state_e;
    typedef struct packed {
        logic [3:0]    cmd;
        logic [1:0]    tag;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } entry_t;

    state_e        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [1:0]    tag_q, tag_d;
    logic [DW-1:0] op1_q, op1_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        head;
    logic [AW:0]   wr_q, rd_q;
    logic          full, cmd_ok, push, rej;
    logic [1:0]    resp_q, resp_d, otag_q, otag_d, ptag_q, ptag_d;
    logic [DW-1:0] odata_q, odata_d;
    logic          pend_q, pend_d;

    assign empty_o = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign cmd_ok  = cmd_q inside {4'd1, 4'd2, 4'd5, 4'd6};

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tag_d   = tag_q;
        op1_d   = op1_q;
        push    = 1'b0;
        rej     = 1'b0;
        case (state_q)
            ST_IDLE: if (cmd_i != 4'd0) begin
                cmd_d   = cmd_i;
                tag_d   = tag_i;
                op1_d   = data_i;
                state_d = ST_OP2;
            end
            ST_OP2: begin
                state_d = ST_IDLE;
                // A same-cycle pop frees a slot, so a full FIFO still accepts.
                if (cmd_ok && (!full || pop_i)) push = 1'b1;
                else                            rej  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU result wins the output slot; a colliding reject waits one cycle.
    always_comb begin
        resp_d  = 2'd0;
        otag_d  = 2'd0;
        odata_d = '0;
        pend_d  = pend_q;
        ptag_d  = ptag_q;
        if (res_hit_i) begin
            resp_d  = res_resp_i;
            otag_d  = res_tag_i;
            odata_d = res_data_i;
            if (rej) begin
                pend_d = 1'b1;
                ptag_d = tag_q;
            end
        end else if (pend_q) begin
            resp_d = 2'd2;
            otag_d = ptag_q;
            pend_d = rej;
            if (rej) ptag_d = tag_q;
        end else if (rej) begin
            resp_d = 2'd2;
            otag_d = tag_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            tag_q   <= '0;
            op1_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            resp_q  <= '0;
            otag_q  <= '0;
            odata_q <= '0;
            pend_q  <= 1'b0;
            ptag_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tag_q   <= tag_d;
            op1_q   <= op1_d;
            if (push)  wr_q <= wr_q + PTR_ONE;
            if (pop_i) rd_q <= rd_q + PTR_ONE;
            resp_q  <= resp_d;
            otag_q  <= otag_d;
            odata_q <= odata_d;
            pend_q  <= pend_d;
            ptag_q  <= ptag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= '{cmd: cmd_q, tag: tag_q, op1: op1_q, op2: data_i};
    end

    assign head       = mem_q[rd_q[AW-1:0]];
    assign head_cmd_o = head.cmd;
    assign head_tag_o = head.tag;
    assign head_op1_o = head.op1;
    assign head_op2_o = head.op2;
    assign resp_o     = resp_q;
    assign tag_o      = otag_q;
    assign data_o     = odata_q;
endmodule

module cal_req_scheduler #(
    parameter int NPORTS     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 32
) (
    input logic                clk,
    input logic                reset,
    cal_req_scheduler_if.master bus
);
    logic [NPORTS-1:0]         empty, pop;
    logic [NPORTS-1:0][3:0]    h_cmd;
    logic [NPORTS-1:0][1:0]    h_tag;
    logic [NPORTS-1:0][DW-1:0] h_op1, h_op2;
    logic [NPORTS-1:0][1:0]    o_resp, o_tag;
    logic [NPORTS-1:0][DW-1:0] o_data;
    logic [1:0]                rr_q, rr_d, pick, grant, hold_port_q, hold_port_d;
    logic                      hold_q, hold_d, any, hs;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign pop[p] = hs && (grant == 2'(p));
        cal_req_port #(.FIFO_DEPTH(FIFO_DEPTH), .DW(DW)) u_port (
            .clk        (clk),
            .reset      (reset),
            .cmd_i      (bus.req_cmd_in[p]),
            .tag_i      (bus.req_tag_in[p]),
            .data_i     (bus.req_data_in[p]),
            .pop_i      (pop[p]),
            .res_hit_i  (bus.res_valid && (bus.res_port == 2'(p))),
            .res_resp_i (bus.res_resp),
            .res_tag_i  (bus.res_tag),
            .res_data_i (bus.res_data),
            .empty_o    (empty[p]),
            .head_cmd_o (h_cmd[p]),
            .head_tag_o (h_tag[p]),
            .head_op1_o (h_op1[p]),
            .head_op2_o (h_op2[p]),
            .resp_o     (o_resp[p]),
            .tag_o      (o_tag[p]),
            .data_o     (o_data[p])
        );
    end

    // Lowest offset from rr_q wins; loop runs high-to-low so the last hit is it.
    always_comb begin
        pick = rr_q;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (!empty[rr_q + 2'(i)]) pick = rr_q + 2'(i);
        end
    end

    // A stalled grant is frozen so a newly filled, higher-priority FIFO cannot
    // swap the payload under a waiting ALU.
    assign any         = ~&empty;
    assign grant       = hold_q ? hold_port_q : pick;
    assign hs          = any && bus.alu_ready;
    assign hold_d      = any && !bus.alu_ready;
    assign hold_port_d = grant;
    assign rr_d        = hs ? grant + 2'd1 : rr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q        <= '0;
            hold_q      <= 1'b0;
            hold_port_q <= '0;
        end else begin
            rr_q        <= rr_d;
            hold_q      <= hold_d;
            hold_port_q <= hold_port_d;
        end
    end

    assign bus.alu_valid = any;
    assign bus.alu_cmd   = any ? h_cmd[grant] : '0;
    assign bus.alu_op1   = any ? h_op1[grant] : '0;
    assign bus.alu_op2   = any ? h_op2[grant] : '0;
    assign bus.alu_port  = any ? grant        : '0;
    assign bus.alu_tag   = any ? h_tag[grant] : '0;
    assign bus.out_resp  = o_resp;
    assign bus.out_tag   = o_tag;
    assign bus.out_data  = o_data;
endmodule

// File: doc/cal_req_scheduler.md
Name: cal_req_scheduler

Overview:
- Front-end scheduler that lets the four calculator requester ports share a single ALU engine.
- Captures each port's two-cycle command (cmd+tag+operand1, then operand2) into a per-port FIFO.
- Issues queued commands to the ALU with round-robin arbitration and a valid/ready handshake.
- Routes each ALU result, or a locally generated reject, back to the originating port with its tag.

Parameters:
- NPORTS, 4, number of requester ports (2-bit port id; fixed at 4 in this revision).
- FIFO_DEPTH, 4, per-port command FIFO entries (power of two, >=2).
- DW, 32, operand/result width.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- req_cmd_in  input  4*NPORTS  per-port command; 0=no-op; 1=add, 2=sub, 5=shl, 6=shr valid; any other nonzero value is invalid.
- req_tag_in  input  2*NPORTS  per-port tag, sampled with cmd.
- req_data_in  input  DW*NPORTS  operand1 in the cmd cycle, operand2 in the following cycle.
- out_resp  output  2*NPORTS  per-port response pulse: 0=none, 1=ALU result, 2=reject/invalid/overflow.
- out_tag  output  2*NPORTS  tag accompanying out_resp.
- out_data  output  DW*NPORTS  result data; 0 when out_resp is 0 or 2 from a local reject.
- alu_valid  output  1  command presented to the ALU.
- alu_cmd  output  4  command to the ALU.
- alu_op1  output  DW  operand1 to the ALU.
- alu_op2  output  DW  operand2 to the ALU.
- alu_port  output  2  originating port; echoed back by the ALU.
- alu_tag  output  2  originating tag; echoed back by the ALU.
- alu_ready  input  1  ALU accepts the command this cycle.
- res_valid  input  1  ALU result valid (single-cycle pulse).
- res_port  input  2  port id echoed by the ALU.
- res_tag  input  2  tag echoed by the ALU.
- res_data  input  DW  result data from the ALU.
- res_resp  input  2  ALU response code (1 or 2).

Behaviour:
- Reset: all outputs 0; FIFOs emptied; capture FSMs to IDLE; RR pointer = 0; pending rejects cleared. Reset mid-operation discards partially captured and queued commands. res_valid is ignored while reset is high.
- Per-port capture FSM, IDLE:
  - cmd=0 -> stay IDLE.
  - cmd!=0 -> latch cmd, tag, operand1; go to OP2.
- Per-port capture FSM, OP2 (exactly one cycle):
  - Latch operand2 from req_data_in; return to IDLE. Any cmd present in this cycle is ignored.
  - Valid cmd with FIFO not full -> push {cmd, tag, op1, op2}.
  - Invalid cmd, or FIFO full -> no push; raise a reject (resp=2, captured tag).
- Push becomes visible to arbitration the cycle after the OP2 cycle. Minimum latency from cmd cycle to alu_valid is 2 cycles.
- Arbitration:
  - When alu_valid=0, or alu_valid=1 and alu_ready=1, pick the first non-empty FIFO searching from rr_ptr upward, mod 4.
  - Drive alu_* from that FIFO head on the next cycle.
  - On handshake (alu_valid & alu_ready): pop the head; rr_ptr = granted port + 1 mod 4.
- ALU output stability: alu_* payload and alu_valid hold stable while alu_valid=1 and alu_ready=0. alu_valid may be high back to back.
- Per-port FIFO ordering: strict FIFO order. Commands from different ports are ordered only by the arbiter.
- Response output:
  - res_valid -> out_resp[res_port]=res_resp, out_tag=res_tag, out_data=res_data for one cycle, registered (1-cycle latency).
  - A reject drives out_resp=2, out_tag, out_data=0 for one cycle.
- Simultaneous events:
  - ALU result and reject on the same port in the same cycle: ALU result goes first; the reject is held in a 1-entry pending register and is emitted the next cycle. Captures take >=2 cycles, so the pending register cannot overflow.
  - Push and pop on the same FIFO in the same cycle are allowed, including when full.
- FIFO pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- Tags are not checked for reuse; duplicate outstanding tags are passed through unchanged.

Test Plan:
- Port0 cmd=1, tag=2, op1=5 then op2=7; ALU ready, echoes 12 two cycles later -> alu_cmd=1/op1=5/op2=7/port=0/tag=2 at cmd+2; out_resp[0]=1, out_tag[0]=2, out_data[0]=12 one cycle after res_valid.
- All four ports issue add in the same cycle, alu_ready=1 -> ALU grants in order 0,1,2,3. Then port2 and port0 pending with rr_ptr=0 after grant 3 -> grant port0 then port2.
- alu_ready=0 for 10 cycles with port1 issuing 6 commands -> first 4 queued; 5th and 6th get out_resp[1]=2 with their tags. alu_* held stable throughout. After release, 4 commands issue in order.
- Port3 cmd=9, tag=1 -> no ALU issue; out_resp[3]=2, out_tag[3]=1, out_data[3]=0. Repeat with res_valid for port3 in the same cycle -> result first, reject the next cycle.
- Assert reset while port2 is in OP2 and FIFOs hold entries -> all outputs 0 immediately. After release, no stale alu_valid or responses; new commands work.
